program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that sits directly upstream of the single-cycle core's instruction memory. It assembles a byte stream from a serial receiver into 32-bit words and writes them sequentially into instruction memory, holding the core in reset until the load completes. It then releases the core to fetch from word 0.

## Interface
Parameters:
- WORD_SIZE, 32, instruction word width; only 32 is supported, 4 bytes per word.
- DEPTH, 256, instruction memory capacity in words.
- TIMEOUT, 1000000, maximum idle cycles allowed between bytes once a load is in progress.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- start  in  1  re-arm pulse; honoured only in DONE or ERROR.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  $clog2(DEPTH)  word index being written.
- imem_data  out  WORD_SIZE  word being written.
- core_rst_n  out  1  core reset, active-low; high only in DONE.
- done  out  1  high while in DONE.
- err_code  out  2  0 = none, 1 = overflow, 2 = timeout, 3 = checksum; holds until re-arm.

## Operation
- Stream format: a 32-bit header N (word count), then N data words; with LOADER_CHECKSUM_EN, one additional checksum word. All words are big-endian: first byte goes to bits 31:24.
- A byte counter (0..3) assembles words. The word is complete when the 4th byte is accepted.
- States and transitions:
  - IDLE: wait for the first byte. On rx_valid, take byte 0 of the header and go to HEADER.
  - HEADER: on header completion:
    - N > DEPTH: go to ERROR with err_code = 1.
    - N = 0: go to CHECK if the checksum is enabled, otherwise go to DONE.
    - Otherwise: go to LOAD.
  - LOAD: each completed word is written at imem_addr = word index, which starts at 0. After word N-1 is written, go to CHECK (checksum enabled) or DONE.
  - CHECK: assemble the checksum word and compare it, then go to DONE on a match or to ERROR with err_code = 3 on a mismatch.
  - DONE: rx_valid is ignored. A start pulse goes to IDLE.
  - ERROR: rx_valid is ignored. A start pulse goes to IDLE and clears err_code.
- Timeout:
  - The counter is cleared on every accepted byte.
  - It counts in HEADER, LOAD and CHECK.
  - When it reaches TIMEOUT, go to ERROR with err_code = 2. A partial word is discarded and not written.
- Simultaneous start and rx_valid in DONE or ERROR: start wins and the byte is discarded.
- start in IDLE, HEADER, LOAD or CHECK has no effect.
- Words already written before an error remain in memory. The core stays in reset.

## Timing
- Reset values:
  - state = IDLE.
  - core_rst_n = 0, done = 0, err_code = 0, imem_we = 0.
  - imem_addr = 0, imem_data = 0.
  - Byte counter, word index and timeout counter = 0.
- Write latency: if the 4th byte of a data word is accepted in cycle t, then in cycle t+1 imem_we = 1 with stable imem_addr and imem_data. imem_we is low in all other cycles.
- One byte per cycle is accepted (back-to-back rx_valid). No backpressure is applied.
- done and core_rst_n rise in the cycle after the state register enters DONE. They rise together.
- done and core_rst_n drop in the cycle after the start pulse.
- Asserting rst mid-load aborts immediately:
  - Outputs return to their reset values.
  - The memory contents already written are untouched.
- The timeout fires on exactly the TIMEOUT-th consecutive cycle without rx_valid.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A trailing checksum word is expected after the data words.
  - The checksum is the sum of the data words modulo 2^32. The header is excluded.
  - The CHECK state is present.
- LOADER_CHECKSUM_EN undefined:
  - There is no CHECK state and no checksum word.
  - The transition to DONE occurs directly after the last data word.
  - err_code never takes the value 3.

## Test plan
- Basic load: header 2, then 0x20080005 and 0x01084020, back-to-back, plus checksum 0x21104025 if enabled. Required response:
  - Writes at addr 0 and addr 1 with those data values.
  - imem_we pulses one cycle after each 4th byte.
  - done = 1 and core_rst_n = 1.
- Overflow: with DEPTH = 256, send header 257. Required response: ERROR, err_code = 1, no imem_we, core_rst_n = 0.
- Timeout: with TIMEOUT = 100, send header 1, 2 data bytes, then silence. Required response: err_code = 2 on exactly the 100th idle cycle, no write.
- Checksum mismatch (LOADER_CHECKSUM_EN): header 1, data 0x00000001, checksum 0x00000002. Required response: the write at addr 0 occurs, then err_code = 3 and done = 0.
- Re-arm:
  - After DONE, a start pulse gives core_rst_n = 0 and done = 0 in the next cycle.
  - A second load with header 0 reaches DONE (after checksum 0x00000000 if enabled) with no writes.
- Reset mid-load: drop rst after 1 of 3 data words have been written. Required response:
  - All outputs are at reset values immediately, state is IDLE.
  - A following full load writes starting at addr 0.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time loader that streams bytes into instruction memory
//
// Assembles big-endian 32-bit words from a byte receiver and writes them
// sequentially into instruction memory, holding the core in reset until the
// image is complete. Stream: header word N, then N data words, then (only
// when LOADER_CHECKSUM_EN is defined) a checksum word equal to the sum of the
// data words modulo 2^32.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle byte strobe
//   start      re-arm pulse, honoured only in DONE or ERROR
//   imem_we    one-cycle write strobe per completed data word
//   imem_addr  word index being written
//   imem_data  word being written
//   core_rst_n core reset, released only while loaded (DONE)
//   done       high while loaded
//   err_code   0 none, 1 overflow, 2 timeout, 3 checksum; held until re-arm
//
// Optional feature macro: LOADER_CHECKSUM_EN (trailing checksum word + CHECK state).

module program_loader #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 256,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     start,
  output logic                     imem_we,
  output logic [$clog2(DEPTH)-1:0] imem_addr,
  output logic [WORD_SIZE-1:0]     imem_data,
  output logic                     core_rst_n,
  output logic                     done,
  output logic [1:0]               err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);   // N may equal DEPTH
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // Where the FSM goes once the last data word (or an empty header) is seen.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHECK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t                 state, state_nxt;
  logic [1:0]             err_nxt;
  logic [1:0]             byte_cnt;
  logic [WORD_SIZE-9:0]   shift;
  logic [NW-1:0]          n_words;
  logic [AW-1:0]          widx;
  logic [TW-1:0]          tcnt;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_SIZE-1:0]   sum;
`endif

  logic                   busy;
  logic                   accept;
  logic                   word_done;
  logic                   timeout_hit;
  logic                   last_word;
  logic [WORD_SIZE-1:0]   word;

  // States in which bytes are consumed and the idle timer runs.
  always_comb begin
    busy = (state == S_HEADER) || (state == S_LOAD);
`ifdef LOADER_CHECKSUM_EN
    if (state == S_CHECK) busy = 1'b1;
`endif
  end

  assign accept      = rx_valid && ((state == S_IDLE) || busy);
  assign word_done   = accept && (byte_cnt == 2'd3);
  assign word        = {shift, rx_data};
  // Counter holds k-1 during the k-th idle cycle, so this fires on the
  // TIMEOUT-th consecutive idle cycle.
  assign timeout_hit = busy && !rx_valid && (tcnt == TW'(TIMEOUT - 1));
  assign last_word   = (NW'(widx) + NW'(1)) == n_words;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      S_IDLE: begin
        if (rx_valid) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (timeout_hit) begin
          state_nxt = S_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end else if (word_done) begin
          if (word > WORD_SIZE'(DEPTH)) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_OVERFLOW;
          end else if (word == '0) begin
            state_nxt = S_AFTER_DATA;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (timeout_hit) begin
          state_nxt = S_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end else if (word_done && last_word) begin
          state_nxt = S_AFTER_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (timeout_hit) begin
          state_nxt = S_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end else if (word_done) begin
          if (word == sum) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_CHECKSUM;
          end
        end
      end
`endif
      S_DONE: begin
        if (start) state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_nxt = S_IDLE;
          err_nxt   = ERR_NONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_data  <= '0;
      done       <= 1'b0;
      core_rst_n <= 1'b0;
      byte_cnt   <= '0;
      shift      <= '0;
      n_words    <= '0;
      widx       <= '0;
      tcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we    <= 1'b0;
      // Registered from the current state: rises one cycle after entering
      // DONE, and a start pulse drops it on the same edge that leaves DONE.
      done       <= (state == S_DONE) && !start;
      core_rst_n <= (state == S_DONE) && !start;

      if (accept) begin
        tcnt     <= '0;
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= word[WORD_SIZE-9:0];
      end else if (busy) begin
        tcnt <= tcnt + 1'b1;
      end

      if ((state == S_HEADER) && word_done) begin
        n_words <= NW'(word);
        widx    <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum     <= '0;
`endif
      end

      if ((state == S_LOAD) && word_done) begin
        imem_we   <= 1'b1;
        imem_addr <= widx;
        imem_data <= word;
        widx      <= widx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum       <= sum + word;
`endif
      end

      // Any partial word is dropped on error so a re-arm starts aligned.
      if (state_nxt == S_ERROR) begin
        byte_cnt <= '0;
        tcnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        start = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        core_rst_n;
  logic        done;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];

  program_loader #(.WORD_SIZE(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .start(start),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .core_rst_n(core_rst_n), .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write, including
  // the cycle it appears in (one cycle after the 4th byte).
  always @(negedge clk) begin
    if (rst && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=0x%0h data=0x%0h", imem_addr, imem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'h0, imem_addr}, e.addr);
        check("wr_data", imem_data, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Random idle gap with stray start pulses, which must be ignored mid-load.
  task automatic gap();
    int n;
    n = $urandom_range(1, 5);
    repeat (n) begin
      start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit is_data, input int addr);
    for (int i = 0; i < 4; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) gap();
      send_byte(w[31-8*i -: 8]);
    end
    if (is_data) exp_q.push_back('{addr, w, cyc});
  endtask

  // Reference: header, data words written at 0..N-1, optional sum trailer,
  // DONE visible the cycle after the final byte's state change.
  task automatic do_load(input logic [31:0] words[$], input bit gaps);
    logic [31:0] s;
    s = 32'h0;
    send_word(32'(words.size()), gaps, 1'b0, 0);
    foreach (words[i]) begin
      send_word(words[i], gaps, 1'b1, i);
      s = s + words[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(s, gaps, 1'b0, 0);
`endif
    check("done_not_yet", {31'h0, done}, 32'h0);
    check("core_rst_not_yet", {31'h0, core_rst_n}, 32'h0);
    idle(1);
    check("done_high", {31'h0, done}, 32'h1);
    check("core_rst_n_high", {31'h0, core_rst_n}, 32'h1);
    check("err_none", {30'h0, err_code}, 32'h0);
  endtask

  task automatic rearm(input bit with_byte);
    start = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data = 8'hAA;
    end
    @(posedge clk); #1;
    start = 1'b0;
    rx_valid = 1'b0;
    check("rearm_done", {31'h0, done}, 32'h0);
    check("rearm_core_rst_n", {31'h0, core_rst_n}, 32'h0);
    check("rearm_err", {30'h0, err_code}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, {31'h0, imem_we}, 32'h0);
    check({tag, "_addr"}, {24'h0, imem_addr}, 32'h0);
    check({tag, "_data"}, imem_data, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_core_rst_n"}, {31'h0, core_rst_n}, 32'h0);
    check({tag, "_err"}, {30'h0, err_code}, 32'h0);
  endtask

  initial begin
    logic [31:0] q[$];
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(1);

    // Basic two-word program; bytes in DONE must be ignored.
    q = {};
    q.push_back(32'h20080005);
    q.push_back(32'h01084020);
    do_load(q, 1'b0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("done_holds", {31'h0, done}, 32'h1);
    rearm(1'b1);

    // Empty program.
    q = {};
    do_load(q, 1'b0);
    rearm(1'b0);

    // Overflow: header DEPTH+1.
    send_word(32'(DEPTH + 1), 1'b0, 1'b0, 0);
    check("ovf_err", {30'h0, err_code}, 32'h1);
    check("ovf_core_rst_n", {31'h0, core_rst_n}, 32'h0);
    send_word(32'h12345678, 1'b0, 1'b0, 0);
    check("ovf_err_holds", {30'h0, err_code}, 32'h1);
    check("ovf_done", {31'h0, done}, 32'h0);
    rearm(1'b1);

    // Timeout after a partial data word.
    send_word(32'h1, 1'b0, 1'b0, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 1; i <= TIMEOUT; i++) begin
      idle(1);
      if (i == TIMEOUT - 1) check("tmo_early", {30'h0, err_code}, 32'h0);
      if (i == TIMEOUT) check("tmo_err", {30'h0, err_code}, 32'h2);
    end
    check("tmo_core_rst_n", {31'h0, core_rst_n}, 32'h0);
    rearm(1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum mismatch: the data word is still written.
    send_word(32'h1, 1'b0, 1'b0, 0);
    send_word(32'h1, 1'b0, 1'b1, 0);
    send_word(32'h2, 1'b0, 1'b0, 0);
    check("csum_err", {30'h0, err_code}, 32'h3);
    idle(1);
    check("csum_done", {31'h0, done}, 32'h0);
    rearm(1'b0);
`endif

    // Randomized programs with random gaps and stray start pulses.
    for (int r = 0; r < 6; r++) begin
      q = {};
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) q.push_back($urandom);
      do_load(q, 1'b1);
      rearm(1'($urandom_range(0, 1)));
    end

    // Full-capacity program (N = DEPTH).
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
    do_load(q, 1'b0);
    rearm(1'b0);

    // Reset mid-load after the first of three words is written.
    send_word(32'h3, 1'b0, 1'b0, 0);
    send_word(32'hCAFEF00D, 1'b0, 1'b1, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    q = {};
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    do_load(q, 1'b0);
    rearm(1'b0);

    idle(3);
    check("pending_writes", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
